program_memory: RTL and testbench
=================================

Name: program_memory

Overview:
- 16 x 8 SAP-1 RAM: the consumer of the 4-bit address held by the memory address register.
- Run mode: synchronous reads at the presented address, result driven toward the W bus.
- Program mode: a byte-stream loader with a valid/ready handshake fills memory from address 0 upward.
- Sits between the memory address register and the bus, beside the instruction register.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH = 16

Ports:
i_clock  input  1  system clock; all state updates on rising edge
i_reset  input  1  synchronous reset, active-low (reset when 0 at a rising edge of i_clock)
i_debug  input  1  when 1, print load/read/mode events to the simulation log
i_address  input  ADDR_WIDTH  read address from the memory address register
i_output_enable  input  1  request a read of mem[i_address] onto the bus
o_data  output  DATA_WIDTH  registered read data; 0 when not driving
o_data_valid  output  1  o_data holds a valid read result
i_prog_mode  input  1  level; 1 requests program mode
i_prog_valid  input  1  i_prog_data holds a byte to write
i_prog_data  input  DATA_WIDTH  byte to store
o_prog_ready  output  1  loader accepts a byte this cycle
o_prog_count  output  ADDR_WIDTH+1  bytes written in the current program session (0..16)
o_prog_done  output  1  all 16 locations written in this session

Behaviour:
- Reset, checked every rising edge:
  - When i_reset=0: every memory word <= 0.
  - State <= RUN; write pointer <= 0.
  - o_data=0, o_data_valid=0, o_prog_ready=0, o_prog_count=0, o_prog_done=0.
  - Reset overrides all other inputs, including mid-session. A partial program session is discarded and memory is cleared.
- States: RUN, PROGRAM, DONE.
- RUN:
  - If i_output_enable=1 at edge N, then from edge N: o_data=mem[i_address sampled at N], o_data_valid=1. Latency is 1 clock.
  - If i_output_enable=0: o_data=0, o_data_valid=0 at the next edge.
  - o_prog_ready=0 and i_prog_valid is ignored.
  - If i_prog_mode=1 at an edge: go to PROGRAM; write pointer <= 0; o_prog_count <= 0; o_prog_done <= 0.
  - If i_prog_mode=1 and i_output_enable=1 at the same edge: program mode wins; o_data=0, o_data_valid=0.
- PROGRAM:
  - o_prog_ready=1, combinational from state.
  - o_data=0, o_data_valid=0; i_output_enable and i_address are ignored.
  - On an edge with i_prog_valid=1: mem[pointer] <= i_prog_data; pointer++; o_prog_count++.
  - The write that makes o_prog_count=16 moves the FSM to DONE and sets o_prog_done=1.
  - If i_prog_mode=0 at an edge: return to RUN; any write on that same edge is NOT performed; locations already written are kept; o_prog_done stays 0.
- DONE:
  - o_prog_ready=0; o_prog_done=1; o_prog_count=16; further i_prog_valid is ignored (no wrap, no overwrite of address 0).
  - If i_prog_mode=0: go to RUN; o_prog_done and o_prog_count hold their values until the next PROGRAM entry.
- Write pointer is ADDR_WIDTH bits. It never wraps within a session; exhaustion is detected via o_prog_count.
- Debug: if i_debug=1, $display on each stored byte (address, data), on each read, and on each state change. Debug has no functional effect.

Test Plan:
- Reset state: hold i_reset=0 for 2 clocks with i_output_enable=1 -> o_data=0, o_data_valid=0, o_prog_ready=0, o_prog_count=0; after release, a read of address 5 gives 8'h00.
- Full load and readback: i_prog_mode=1, stream bytes 8'h10..8'h1F back-to-back -> 16 writes; o_prog_done=1 on the edge of the 16th write; o_prog_ready=0 afterwards. Drop i_prog_mode, read addresses 0..15 -> 8'h10..8'h1F, each one clock after its request.
- Handshake gaps and overflow: in PROGRAM, alternate i_prog_valid 1/0 for 16 bytes -> o_prog_count increments only on valid edges. A 17th byte (8'hFF) while in DONE -> address 0 keeps its first value.
- Abort mid-session: write 8'hA1, 8'hA2, 8'hA3, then i_prog_mode=0 with i_prog_valid=1 and 8'hA4 -> RUN; addresses 0..2 = A1..A3; address 3 unchanged (0); o_prog_done=0.
- Reset mid-operation: after 5 writes, pull i_reset=0 for one clock -> state RUN, o_prog_count=0, all addresses read 8'h00.
- Read gating: in RUN, toggle i_output_enable each cycle at address 7 holding 8'h5C -> o_data alternates 8'h5C/8'h00 and o_data_valid alternates 1/0, each 1 clock behind the enable.

Source files
------------

// File: rtl/program_memory_if.sv
// Bus bundle between the SAP-1 address/control side and the 16x8 program memory.
// Carries the run-mode read port and the program-mode byte loader handshake.
// The memory uses the slave modport; the driver of addresses and bytes uses master.
interface program_memory_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] i_address;
  logic                  i_output_enable;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_data_valid;
  logic                  i_prog_mode;
  logic                  i_prog_valid;
  logic [DATA_WIDTH-1:0] i_prog_data;
  logic                  o_prog_ready;
  logic [ADDR_WIDTH:0]   o_prog_count;
  logic                  o_prog_done;

  modport master (
    output i_address, i_output_enable, i_prog_mode, i_prog_valid, i_prog_data,
    input  o_data, o_data_valid, o_prog_ready, o_prog_count, o_prog_done
  );

  modport slave (
    input  i_address, i_output_enable, i_prog_mode, i_prog_valid, i_prog_data,
    output o_data, o_data_valid, o_prog_ready, o_prog_count, o_prog_done
  );
endinterface

// File: rtl/program_memory.sv
// SAP-1 16x8 program RAM: registered reads in RUN, sequential byte loader in PROGRAM.
// Read latency 1 clock; each accepted loader byte is written on the accepting edge.
// Loader is ready only in PROGRAM; after 16 bytes (DONE) further bytes are refused.
module program_memory #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_debug,
  program_memory_if.slave        bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Count value just before the final write of a session.
  localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PROGRAM = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  data_vld_q, data_vld_d;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Next-state, loader write enable and next read-port values.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    done_d     = done_q;
    data_d     = '0;
    data_vld_d = 1'b0;
    wr_en      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.i_prog_mode) begin
          // Entering program mode takes priority over a pending read.
          state_d  = PROGRAM;
          wr_ptr_d = '0;
          count_d  = '0;
          done_d   = 1'b0;
        end else if (bus.i_output_enable) begin
          data_d     = mem_q[bus.i_address];
          data_vld_d = 1'b1;
        end
      end
      PROGRAM: begin
        if (!bus.i_prog_mode) begin
          // Abort: a byte offered on the leaving edge is dropped.
          state_d = RUN;
        end else if (bus.i_prog_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
          if (count_q == LAST_CNT) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        // Memory is full; count and done hold until the next session starts.
        if (!bus.i_prog_mode) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, outputs and memory; synchronous active-low reset clears everything.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q    <= RUN;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      data_q     <= '0;
      data_vld_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      done_q     <= done_d;
      data_q     <= data_d;
      data_vld_q <= data_vld_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= bus.i_prog_data;
      end
    end
  end

  assign bus.o_data       = data_q;
  assign bus.o_data_valid = data_vld_q;
  assign bus.o_prog_ready = (state_q == PROGRAM);
  assign bus.o_prog_count = count_q;
  assign bus.o_prog_done  = done_q;

`ifndef SYNTHESIS
  // Simulation trace of loads, reads and state changes when debug is on.
  always @(posedge i_clock) begin
    if (i_debug && i_reset) begin
      if (wr_en) begin
        $display("[program_memory] store addr=%0d data=%02h", wr_ptr_q, bus.i_prog_data);
      end
      if (data_vld_d) begin
        $display("[program_memory] read addr=%0d data=%02h", bus.i_address, data_d);
      end
      if (state_d != state_q) begin
        $display("[program_memory] state %s -> %s", state_q.name(), state_d.name());
      end
    end
  end
`endif

endmodule

// File: tb/tb_program_memory.sv
// Directed self-checking bench for program_memory.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Each comparison is an immediate assertion whose failure bumps the miscompare count.
module tb_program_memory;

  logic clk;
  logic rst_n;
  logic dbg;
  int   vectors;
  int   miscompares;

  program_memory_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  program_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .i_debug (dbg),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle read: present address with enable, result one clock later.
  task automatic read_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
    bus.i_output_enable = 1'b1;
    bus.i_address       = a;
    tick();
    check(tag, {24'd0, bus.o_data}, {24'd0, exp});
    check({tag, "_vld"}, {31'd0, bus.o_data_valid}, 32'd1);
    bus.i_output_enable = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    vectors              = 0;
    miscompares          = 0;
    dbg                  = 1'b0;
    rst_n                = 1'b0;
    bus.i_address        = 4'd5;
    bus.i_output_enable  = 1'b1;
    bus.i_prog_mode      = 1'b0;
    bus.i_prog_valid     = 1'b0;
    bus.i_prog_data      = 8'h00;

    // Reset held 2 clocks with a read requested.
    tick();
    tick();
    check("rst_data",  {24'd0, bus.o_data}, 32'h0);
    check("rst_vld",   {31'd0, bus.o_data_valid}, 32'd0);
    check("rst_ready", {31'd0, bus.o_prog_ready}, 32'd0);
    check("rst_count", {27'd0, bus.o_prog_count}, 32'd0);
    check("rst_done",  {31'd0, bus.o_prog_done}, 32'd0);
    rst_n = 1'b1;
    read_check("rst_rd5", 4'd5, 8'h00);

    // Program mode and a read on the same edge: program mode wins.
    bus.i_output_enable = 1'b1;
    bus.i_address       = 4'd5;
    bus.i_prog_mode     = 1'b1;
    tick();
    bus.i_output_enable = 1'b0;
    check("pm_win_vld",   {31'd0, bus.o_data_valid}, 32'd0);
    check("pm_win_ready", {31'd0, bus.o_prog_ready}, 32'd1);
    check("pm_win_count", {27'd0, bus.o_prog_count}, 32'd0);

    // Full load of 0x10..0x1F back-to-back.
    for (int i = 0; i < 16; i++) begin
      bus.i_prog_valid = 1'b1;
      bus.i_prog_data  = 8'h10 + 8'(i);
      tick();
      check("load_count", {27'd0, bus.o_prog_count}, 32'(i + 1));
      check("load_done",  {31'd0, bus.o_prog_done}, (i == 15) ? 32'd1 : 32'd0);
    end
    bus.i_prog_valid = 1'b0;
    check("full_ready", {31'd0, bus.o_prog_ready}, 32'd0);
    bus.i_prog_mode = 1'b0;
    tick();
    check("run_done_hold",  {31'd0, bus.o_prog_done}, 32'd1);
    check("run_count_hold", {27'd0, bus.o_prog_count}, 32'd16);
    for (int a = 0; a < 16; a++) begin
      read_check("full_rd", 4'(a), 8'h10 + 8'(a));
    end
    tick();
    check("idle_data", {24'd0, bus.o_data}, 32'h0);
    check("idle_vld",  {31'd0, bus.o_data_valid}, 32'd0);

    // Alternating valid gaps, then an overflow byte while DONE.
    bus.i_prog_mode = 1'b1;
    tick();
    check("gap_entry_count", {27'd0, bus.o_prog_count}, 32'd0);
    check("gap_entry_done",  {31'd0, bus.o_prog_done}, 32'd0);
    for (int k = 0; k < 32; k++) begin
      bus.i_prog_valid = (k % 2 == 0);
      bus.i_prog_data  = 8'h20 + 8'(k / 2);
      tick();
      check("gap_count", {27'd0, bus.o_prog_count}, 32'(k / 2 + 1));
    end
    bus.i_prog_valid = 1'b1;
    bus.i_prog_data  = 8'hFF;
    tick();
    bus.i_prog_valid = 1'b0;
    check("ovf_count", {27'd0, bus.o_prog_count}, 32'd16);
    check("ovf_done",  {31'd0, bus.o_prog_done}, 32'd1);
    check("ovf_ready", {31'd0, bus.o_prog_ready}, 32'd0);
    bus.i_prog_mode = 1'b0;
    tick();
    read_check("ovf_rd0",  4'd0,  8'h20);
    read_check("ovf_rd15", 4'd15, 8'h2F);

    // Abort mid-session on fresh memory.
    do_reset();
    bus.i_prog_mode = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.i_prog_valid = 1'b1;
      bus.i_prog_data  = 8'hA1 + 8'(i);
      tick();
    end
    bus.i_prog_mode  = 1'b0;
    bus.i_prog_valid = 1'b1;
    bus.i_prog_data  = 8'hA4;
    tick();
    bus.i_prog_valid = 1'b0;
    check("abort_ready", {31'd0, bus.o_prog_ready}, 32'd0);
    check("abort_done",  {31'd0, bus.o_prog_done}, 32'd0);
    check("abort_count", {27'd0, bus.o_prog_count}, 32'd3);
    read_check("abort_rd0", 4'd0, 8'hA1);
    read_check("abort_rd1", 4'd1, 8'hA2);
    read_check("abort_rd2", 4'd2, 8'hA3);
    read_check("abort_rd3", 4'd3, 8'h00);

    // Reset after 5 writes, with the loader still active during reset.
    bus.i_prog_mode = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.i_prog_valid = 1'b1;
      bus.i_prog_data  = 8'h30 + 8'(i);
      tick();
    end
    check("pre_rst_count", {27'd0, bus.o_prog_count}, 32'd5);
    rst_n            = 1'b0;
    bus.i_prog_data  = 8'h77;
    tick();
    rst_n            = 1'b1;
    bus.i_prog_mode  = 1'b0;
    bus.i_prog_valid = 1'b0;
    check("mid_rst_count", {27'd0, bus.o_prog_count}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.o_prog_ready}, 32'd0);
    check("mid_rst_done",  {31'd0, bus.o_prog_done}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      read_check("mid_rst_rd", 4'(a), 8'h00);
    end

    // Read gating: address 7 holds 0x5C, enable toggles each cycle.
    bus.i_prog_mode = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.i_prog_valid = 1'b1;
      bus.i_prog_data  = (i == 7) ? 8'h5C : 8'h40 + 8'(i);
      tick();
    end
    bus.i_prog_valid = 1'b0;
    bus.i_prog_mode  = 1'b0;
    tick();
    bus.i_address = 4'd7;
    for (int c = 0; c < 8; c++) begin
      bus.i_output_enable = (c % 2 == 0);
      tick();
      check("gate_data", {24'd0, bus.o_data}, (c % 2 == 0) ? 32'h5C : 32'h0);
      check("gate_vld",  {31'd0, bus.o_data_valid}, (c % 2 == 0) ? 32'd1 : 32'd0);
    end
    bus.i_output_enable = 1'b0;
    read_check("gate_rd6", 4'd6, 8'h46);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
